// File: rtl/l1_l2_glue_ctrl.sv
// L1D/L1I to L2 glue: round-robin arbitration of the single L2 request
// port with response routing, and a whole-hierarchy flush sequencer.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   l1d_req_*, l1i_req_* miss requests (valid, addr, opcode) from each L1
//   l2_req_valid/ack     registered request to L2 and its acceptance
//   l2_req_addr/opcode   address/opcode of the granted side
//   l2_rsp_valid         L2 response complete
//   l1d/l1i_rsp_valid    response routed to the granted L1 (combinational)
//   flush_req_l1d/l1i    core flush requests
//   l1d/l1i/l2_flush_complete  flush done pulses
//   flush_l2_start       one-cycle pulse on entering the L2 flush phase
//   in_flush_mode        flush sequence active
module l1_l2_glue_ctrl #(
  parameter int ADDR_W = 32,
  parameter int OPC_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              l1d_req_valid,
  input  logic [ADDR_W-1:0] l1d_req_addr,
  input  logic [OPC_W-1:0]  l1d_req_opcode,
  input  logic              l1i_req_valid,
  input  logic [ADDR_W-1:0] l1i_req_addr,
  input  logic [OPC_W-1:0]  l1i_req_opcode,
  output logic              l2_req_valid,
  input  logic              l2_req_ack,
  output logic [ADDR_W-1:0] l2_req_addr,
  output logic [OPC_W-1:0]  l2_req_opcode,
  input  logic              l2_rsp_valid,
  output logic              l1d_rsp_valid,
  output logic              l1i_rsp_valid,
  input  logic              flush_req_l1d,
  input  logic              flush_req_l1i,
  input  logic              l1d_flush_complete,
  input  logic              l1i_flush_complete,
  input  logic              l2_flush_complete,
  output logic              flush_l2_start,
  output logic              in_flush_mode
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_L1D = 2'd1,
    GNT_L1I = 2'd2
  } arb_state_t;

  typedef enum logic [2:0] {
    FIDLE     = 3'd0,
    WAIT_BOTH = 3'd1,
    GOT_L1D   = 3'd2,
    GOT_L1I   = 3'd3,
    FLUSH_L2  = 3'd4
  } fl_state_t;

  arb_state_t r_state;
  fl_state_t  f_state;

  logic pend_d;
  logic pend_i;
  logic last_gnt;
  logic req;
  logic np_d;
  logic np_i;

  // Requests seen this cycle or remembered from earlier cycles.
  assign np_d = pend_d | l1d_req_valid;
  assign np_i = pend_i | l1i_req_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      pend_d   <= 1'b0;
      pend_i   <= 1'b0;
      last_gnt <= 1'b0;
      req      <= 1'b0;
    end else begin
      pend_d <= np_d;
      pend_i <= np_i;
      case (r_state)
        IDLE: begin
          // Tie goes to the side not served last.
          if (np_d && (!np_i || last_gnt)) begin
            r_state <= GNT_L1D;
            req     <= 1'b1;
          end else if (np_i) begin
            r_state <= GNT_L1I;
            req     <= 1'b1;
          end
        end
        GNT_L1D: begin
          last_gnt <= 1'b0;
          pend_d   <= 1'b0;
          if (l2_req_ack || l2_rsp_valid)
            req <= 1'b0;
          if (l2_rsp_valid)
            r_state <= IDLE;
        end
        GNT_L1I: begin
          last_gnt <= 1'b1;
          pend_i   <= 1'b0;
          if (l2_req_ack || l2_rsp_valid)
            req <= 1'b0;
          if (l2_rsp_valid)
            r_state <= IDLE;
        end
        default: ;
      endcase
    end
  end

  assign l2_req_valid = req;

  always_comb begin
    l2_req_addr   = l1d_req_addr;
    l2_req_opcode = l1d_req_opcode;
    if (r_state == GNT_L1I) begin
      l2_req_addr   = l1i_req_addr;
      l2_req_opcode = l1i_req_opcode;
    end
  end

  assign l1d_rsp_valid = (r_state == GNT_L1D) && l2_rsp_valid;
  assign l1i_rsp_valid = (r_state == GNT_L1I) && l2_rsp_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      f_state        <= FIDLE;
      in_flush_mode  <= 1'b0;
      flush_l2_start <= 1'b0;
    end else begin
      flush_l2_start <= 1'b0;
      case (f_state)
        FIDLE: begin
          if (flush_req_l1d || flush_req_l1i) begin
            in_flush_mode <= 1'b1;
            // A side not asked to flush counts as already done.
            if (flush_req_l1d && flush_req_l1i)
              f_state <= WAIT_BOTH;
            else if (flush_req_l1i)
              f_state <= GOT_L1D;
            else
              f_state <= GOT_L1I;
          end
        end
        WAIT_BOTH: begin
          if (l1d_flush_complete && l1i_flush_complete) begin
            f_state        <= FLUSH_L2;
            flush_l2_start <= 1'b1;
          end else if (l1d_flush_complete) begin
            f_state <= GOT_L1D;
          end else if (l1i_flush_complete) begin
            f_state <= GOT_L1I;
          end
        end
        GOT_L1D: begin
          if (l1i_flush_complete) begin
            f_state        <= FLUSH_L2;
            flush_l2_start <= 1'b1;
          end
        end
        GOT_L1I: begin
          if (l1d_flush_complete) begin
            f_state        <= FLUSH_L2;
            flush_l2_start <= 1'b1;
          end
        end
        FLUSH_L2: begin
          if (l2_flush_complete) begin
            f_state       <= FIDLE;
            in_flush_mode <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_l2_glue_ctrl.sv
// Bench for l1_l2_glue_ctrl: directed vector table, flush sequences,
// then random traffic against a transaction-level reference model.
module tb_l1_l2_glue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        l1d_req_valid;
  logic [31:0] l1d_req_addr;
  logic [3:0]  l1d_req_opcode;
  logic        l1i_req_valid;
  logic [31:0] l1i_req_addr;
  logic [3:0]  l1i_req_opcode;
  logic        l2_req_valid;
  logic        l2_req_ack;
  logic [31:0] l2_req_addr;
  logic [3:0]  l2_req_opcode;
  logic        l2_rsp_valid;
  logic        l1d_rsp_valid;
  logic        l1i_rsp_valid;
  logic        flush_req_l1d;
  logic        flush_req_l1i;
  logic        l1d_flush_complete;
  logic        l1i_flush_complete;
  logic        l2_flush_complete;
  logic        flush_l2_start;
  logic        in_flush_mode;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  l1_l2_glue_ctrl #(.ADDR_W(32), .OPC_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .l1d_req_valid(l1d_req_valid),
    .l1d_req_addr(l1d_req_addr),
    .l1d_req_opcode(l1d_req_opcode),
    .l1i_req_valid(l1i_req_valid),
    .l1i_req_addr(l1i_req_addr),
    .l1i_req_opcode(l1i_req_opcode),
    .l2_req_valid(l2_req_valid),
    .l2_req_ack(l2_req_ack),
    .l2_req_addr(l2_req_addr),
    .l2_req_opcode(l2_req_opcode),
    .l2_rsp_valid(l2_rsp_valid),
    .l1d_rsp_valid(l1d_rsp_valid),
    .l1i_rsp_valid(l1i_rsp_valid),
    .flush_req_l1d(flush_req_l1d),
    .flush_req_l1i(flush_req_l1i),
    .l1d_flush_complete(l1d_flush_complete),
    .l1i_flush_complete(l1i_flush_complete),
    .l2_flush_complete(l2_flush_complete),
    .flush_l2_start(flush_l2_start),
    .in_flush_mode(in_flush_mode)
  );

  // Reference model: who owns the L2 port (0 none, 1 L1D, 2 L1I),
  // which requests are waiting, and which L1 flushes are outstanding.
  int   m_owner;
  bit   m_pd, m_pi, m_last, m_req;
  int   m_phase;
  bit   m_need_d, m_need_i, m_start;

  function automatic void model_reset();
    m_owner  = 0;
    m_pd     = 0;
    m_pi     = 0;
    m_last   = 0;
    m_req    = 0;
    m_phase  = 0;
    m_need_d = 0;
    m_need_i = 0;
    m_start  = 0;
  endfunction

  function automatic void model_step();
    bit wd, wi;
    if (reset) begin
      model_reset();
      return;
    end
    wd = m_pd || l1d_req_valid;
    wi = m_pi || l1i_req_valid;
    if (m_owner == 0) begin
      m_pd = wd;
      m_pi = wi;
      if (wd || wi) begin
        m_req   = 1;
        m_owner = (wd && (!wi || m_last)) ? 1 : 2;
      end
    end else begin
      m_last = (m_owner == 2);
      if (m_owner == 1) begin
        m_pd = 0;
        m_pi = wi;
      end else begin
        m_pi = 0;
        m_pd = wd;
      end
      if (l2_req_ack || l2_rsp_valid) m_req = 0;
      if (l2_rsp_valid) m_owner = 0;
    end
    m_start = 0;
    case (m_phase)
      0: if (flush_req_l1d || flush_req_l1i) begin
        m_phase  = 1;
        m_need_d = flush_req_l1d;
        m_need_i = flush_req_l1i;
      end
      1: begin
        if (l1d_flush_complete) m_need_d = 0;
        if (l1i_flush_complete) m_need_i = 0;
        if (!m_need_d && !m_need_i) begin
          m_phase = 2;
          m_start = 1;
        end
      end
      default: if (l2_flush_complete) m_phase = 0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_next();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_in();
    l1d_req_valid      = 0;
    l1i_req_valid      = 0;
    l2_req_ack         = 0;
    l2_rsp_valid       = 0;
    flush_req_l1d      = 0;
    flush_req_l1i      = 0;
    l1d_flush_complete = 0;
    l1i_flush_complete = 0;
    l2_flush_complete  = 0;
  endtask

  typedef struct {
    logic        dv, iv, ack, rsp;
    logic        ev;
    logic [31:0] ea;
    logic        ed, ei;
  } vec_t;

  function automatic vec_t mk(logic dv, logic iv, logic ack, logic rsp,
                              logic ev, logic [31:0] ea,
                              logic ed, logic ei);
    vec_t v;
    v.dv = dv; v.iv = iv; v.ack = ack; v.rsp = rsp;
    v.ev = ev; v.ea = ea; v.ed = ed; v.ei = ei;
    return v;
  endfunction

  task automatic fcyc(input string nm, input logic fd, input logic fi,
                      input logic dc, input logic ic, input logic l2c,
                      input logic ef, input logic es);
    zero_in();
    flush_req_l1d      = fd;
    flush_req_l1i      = fi;
    l1d_flush_complete = dc;
    l1i_flush_complete = ic;
    l2_flush_complete  = l2c;
    to_neg();
    chk({nm, "_flush"}, 32'(in_flush_mode), 32'(ef));
    chk({nm, "_start"}, 32'(flush_l2_start), 32'(es));
    to_next();
  endtask

  localparam logic [31:0] A = 32'h1000;
  localparam logic [31:0] B = 32'h2000;

  vec_t tv[27];

  initial begin
    model_reset();
    zero_in();
    l1d_req_addr   = A;
    l1i_req_addr   = B;
    l1d_req_opcode = 4'h3;
    l1i_req_opcode = 4'h5;
    reset = 1;
    to_neg(); to_next();
    to_neg(); to_next();
    reset = 0;
    to_neg();
    chk("rst_valid", 32'(l2_req_valid), 0);
    chk("rst_flush", 32'(in_flush_mode), 0);
    chk("rst_start", 32'(flush_l2_start), 0);
    chk("rst_drsp", 32'(l1d_rsp_valid), 0);
    to_next();

    tv[0]  = mk(1,0,0,0, 0,A,0,0);
    tv[1]  = mk(0,0,0,0, 1,A,0,0);
    tv[2]  = mk(0,0,0,0, 1,A,0,0);
    tv[3]  = mk(0,0,1,0, 1,A,0,0);
    tv[4]  = mk(0,0,0,0, 0,A,0,0);
    tv[5]  = mk(0,0,0,0, 0,A,0,0);
    tv[6]  = mk(0,0,0,1, 0,A,1,0);
    tv[7]  = mk(0,0,0,1, 0,A,0,0);
    tv[8]  = mk(1,1,0,0, 0,A,0,0);
    tv[9]  = mk(0,0,0,0, 1,B,0,0);
    tv[10] = mk(0,0,0,1, 1,B,0,1);
    tv[11] = mk(0,0,0,0, 0,A,0,0);
    tv[12] = mk(0,0,0,0, 1,A,0,0);
    tv[13] = mk(0,0,1,1, 1,A,1,0);
    tv[14] = mk(0,0,0,0, 0,A,0,0);
    tv[15] = mk(0,1,0,0, 0,A,0,0);
    tv[16] = mk(0,0,0,0, 1,B,0,0);
    tv[17] = mk(0,0,0,1, 1,B,0,1);
    tv[18] = mk(1,1,0,0, 0,A,0,0);
    tv[19] = mk(0,0,0,0, 1,A,0,0);
    tv[20] = mk(1,0,0,0, 1,A,0,0);
    tv[21] = mk(0,0,0,1, 1,A,1,0);
    tv[22] = mk(0,0,0,0, 0,A,0,0);
    tv[23] = mk(0,0,0,0, 1,B,0,0);
    tv[24] = mk(0,0,0,1, 1,B,0,1);
    tv[25] = mk(0,0,0,0, 0,A,0,0);
    tv[26] = mk(0,0,0,0, 0,A,0,0);

    for (int k = 0; k < 27; k++) begin
      zero_in();
      l1d_req_valid = tv[k].dv;
      l1i_req_valid = tv[k].iv;
      l2_req_ack    = tv[k].ack;
      l2_rsp_valid  = tv[k].rsp;
      to_neg();
      chk($sformatf("vec%0d_valid", k), 32'(l2_req_valid), 32'(tv[k].ev));
      chk($sformatf("vec%0d_addr", k), l2_req_addr, tv[k].ea);
      chk($sformatf("vec%0d_drsp", k), 32'(l1d_rsp_valid), 32'(tv[k].ed));
      chk($sformatf("vec%0d_irsp", k), 32'(l1i_rsp_valid), 32'(tv[k].ei));
      to_next();
    end

    // Both flushes, L1D done at t, L1I at t+3.
    fcyc("f1a", 1,1,0,0,0, 0,0);
    fcyc("f1b", 0,0,0,0,0, 1,0);
    fcyc("f1c", 0,0,1,0,0, 1,0);
    fcyc("f1d", 0,0,0,0,0, 1,0);
    fcyc("f1e", 0,0,1,0,0, 1,0);
    fcyc("f1f", 0,0,0,1,0, 1,0);
    fcyc("f1g", 1,1,1,0,0, 1,1);
    fcyc("f1h", 0,0,0,0,0, 1,0);
    fcyc("f1i", 0,0,0,0,1, 1,0);
    fcyc("f1j", 0,0,0,0,0, 0,0);
    // L1I only: no L1D completion needed.
    fcyc("f2a", 0,1,0,0,0, 0,0);
    fcyc("f2b", 0,0,0,0,0, 1,0);
    fcyc("f2c", 0,0,0,1,0, 1,0);
    fcyc("f2d", 0,0,0,0,0, 1,1);
    fcyc("f2e", 0,0,0,0,1, 1,0);
    fcyc("f2f", 0,0,0,0,0, 0,0);
    // Both completions together go straight to the L2 phase.
    fcyc("f3a", 1,1,0,0,0, 0,0);
    fcyc("f3b", 0,0,1,1,0, 1,0);
    fcyc("f3c", 0,0,0,0,0, 1,1);
    fcyc("f3d", 0,0,0,0,1, 1,0);
    fcyc("f3e", 0,0,0,0,0, 0,0);

    for (int n = 0; n < 3000; n++) begin
      reset              = ($urandom_range(0, 299) == 0);
      l1d_req_valid      = ($urandom_range(0, 3) == 0);
      l1i_req_valid      = ($urandom_range(0, 3) == 0);
      l1d_req_addr       = $urandom;
      l1i_req_addr       = $urandom;
      l1d_req_opcode     = 4'($urandom);
      l1i_req_opcode     = 4'($urandom);
      l2_req_ack         = ($urandom_range(0, 3) == 0);
      l2_rsp_valid       = ($urandom_range(0, 4) == 0);
      flush_req_l1d      = ($urandom_range(0, 7) == 0);
      flush_req_l1i      = ($urandom_range(0, 7) == 0);
      l1d_flush_complete = ($urandom_range(0, 3) == 0);
      l1i_flush_complete = ($urandom_range(0, 3) == 0);
      l2_flush_complete  = ($urandom_range(0, 5) == 0);
      to_neg();
      chk("rnd_valid", 32'(l2_req_valid), 32'(m_req));
      chk("rnd_addr", l2_req_addr,
          (m_owner == 2) ? l1i_req_addr : l1d_req_addr);
      chk("rnd_opc", 32'(l2_req_opcode),
          32'((m_owner == 2) ? l1i_req_opcode : l1d_req_opcode));
      chk("rnd_drsp", 32'(l1d_rsp_valid),
          32'(m_owner == 1 && l2_rsp_valid));
      chk("rnd_irsp", 32'(l1i_rsp_valid),
          32'(m_owner == 2 && l2_rsp_valid));
      chk("rnd_flush", 32'(in_flush_mode), 32'(m_phase != 0));
      chk("rnd_start", 32'(flush_l2_start), 32'(m_start));
      to_next();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
